// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operation request and HI/LO write bundle of the
// iterative multiply/divide engine.
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] hi_cur;
    logic [31:0] lo_cur;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        hi_write;
    logic        lo_write;

    modport master (
        output start, op, rs_val, rt_val, hi_cur, lo_cur,
        input  busy, done, hi_out, lo_out, hi_write, lo_write
    );

    modport slave (
        input  start, op, rs_val, rt_val, hi_cur, lo_cur,
        output busy, done, hi_out, lo_out, hi_write, lo_write
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: 32-iteration shift-add multiply / restoring divide, 33-cycle latency.
// Define MULDIV_MADD_EN to enable MADD/MADDU accumulate ops (100/101).
module mul_div_unit #(
    parameter int DATA_W = 32,
    parameter int ITERS  = 32
) (
    input logic           clk,
    input logic           rst_n,
    mul_div_unit_if.slave io_bus
);
    localparam int W  = DATA_W;
    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_div;
    logic            r_neg;
    logic            r_rs_neg;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2*W-1:0]  r_acc;
    logic            r_done;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    logic            w_legal;
    logic            w_accept;
    logic            w_sgn;
    logic            w_rs_neg;
    logic            w_rt_neg;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic            w_is_div;
    logic [W:0]      w_msum;
    logic [2*W-1:0]  w_mul_nx;
    logic [W:0]      w_shl;
    logic            w_ge;
    logic [W-1:0]    w_sub;
    logic [2*W-1:0]  w_div_nx;
    logic [2*W-1:0]  w_prod;
    logic [2*W-1:0]  w_mres;
    logic [W-1:0]    w_q;
    logic [W-1:0]    w_r;

`ifdef MULDIV_MADD_EN
    logic            r_madd;
    logic [W-1:0]    r_hic;
    logic [W-1:0]    r_loc;
    assign w_legal = !io_bus.op[2] || (io_bus.op[2:1] == 2'b10);
`else
    assign w_legal = !io_bus.op[2];
`endif

    assign w_accept = io_bus.start && w_legal &&
                      (r_state == S_IDLE || r_state == S_FIX);

    // Even opcodes are the signed variants
    assign w_sgn    = !io_bus.op[0];
    assign w_rs_neg = w_sgn && io_bus.rs_val[W-1];
    assign w_rt_neg = w_sgn && io_bus.rt_val[W-1];
    assign w_a_mag  = w_rs_neg ? -io_bus.rs_val : io_bus.rs_val;
    assign w_b_mag  = w_rt_neg ? -io_bus.rt_val : io_bus.rt_val;
    assign w_is_div = (io_bus.op[2:1] == 2'b01);

    assign w_msum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_nx = {w_msum, r_acc[W-1:1]};

    assign w_shl    = r_acc[2*W-1:W-1];
    assign w_ge     = (w_shl >= {1'b0, r_b});
    assign w_sub    = w_shl[W-1:0] - r_b;
    assign w_div_nx = w_ge ? {w_sub, r_acc[W-2:0], 1'b1}
                           : {w_shl[W-1:0], r_acc[W-2:0], 1'b0};

    assign w_prod = r_neg ? -r_acc : r_acc;
`ifdef MULDIV_MADD_EN
    assign w_mres = r_madd ? (w_prod + {r_hic, r_loc}) : w_prod;
`else
    assign w_mres = w_prod;
`endif

    // Zero divisor: restoring loop already leaves |rs| as remainder
    assign w_q = (r_b == '0) ? '1 :
                 (r_neg ? -r_acc[W-1:0] : r_acc[W-1:0]);
    assign w_r = r_rs_neg ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC:  if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:   w_next = w_accept ? S_CALC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg    <= 1'b0;
            r_rs_neg <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MULDIV_MADD_EN
            r_madd   <= 1'b0;
            r_hic    <= '0;
            r_loc    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt    <= '0;
                r_div    <= w_is_div;
                r_neg    <= w_rs_neg ^ w_rt_neg;
                r_rs_neg <= w_rs_neg;
                r_a      <= w_a_mag;
                r_b      <= w_b_mag;
                r_acc    <= {{W{1'b0}}, w_is_div ? w_a_mag : w_b_mag};
`ifdef MULDIV_MADD_EN
                r_madd   <= io_bus.op[2];
                r_hic    <= io_bus.hi_cur;
                r_loc    <= io_bus.lo_cur;
`endif
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= r_div ? w_div_nx : w_mul_nx;
            end
            if (r_state == S_FIX) begin
                r_done <= 1'b1;
                r_hi   <= r_div ? w_r : w_mres[2*W-1:W];
                r_lo   <= r_div ? w_q : w_mres[W-1:0];
            end
        end
    end

    assign io_bus.busy     = (r_state != S_IDLE);
    assign io_bus.done     = r_done;
    assign io_bus.hi_write = r_done;
    assign io_bus.lo_write = r_done;
    assign io_bus.hi_out   = r_hi;
    assign io_bus.lo_out   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with a queued scoreboard and a
// done-driven monitor checking HI/LO values, strobes and 33-cycle latency.
module tb_mul_div_unit;
    logic clk;
    logic rst_n;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   failures;
    int   n_push;
    int   n_done;
    logic prev_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (bus.done) begin
            exp_t e;
            n_done = n_done + 1;
            checks = checks + 1;
            if (prev_done) begin
                failures = failures + 1;
                $display("FAIL done_width: done high two cycles in a row at cyc %0d", cyc);
            end
            if (sb.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_done: got hi=%h lo=%h at cyc %0d, none expected",
                         bus.hi_out, bus.lo_out, cyc);
            end else begin
                e = sb.pop_front();
                checks = checks + 3;
                if (bus.hi_out !== e.hi || bus.lo_out !== e.lo) begin
                    failures = failures + 1;
                    $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h",
                             e.nm, bus.hi_out, bus.lo_out, e.hi, e.lo);
                end
                if (bus.hi_write !== 1'b1 || bus.lo_write !== 1'b1) begin
                    failures = failures + 1;
                    $display("FAIL %s_strobe: got hw=%b lw=%b, want 1 1",
                             e.nm, bus.hi_write, bus.lo_write);
                end
                if (cyc != e.due) begin
                    failures = failures + 1;
                    $display("FAIL %s_latency: done at cyc %0d, want %0d",
                             e.nm, cyc, e.due);
                end
            end
        end else if (bus.hi_write !== 1'b0 || bus.lo_write !== 1'b0) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL stray_strobe: hw=%b lw=%b without done at cyc %0d",
                     bus.hi_write, bus.lo_write, cyc);
        end
        prev_done = bus.done;
    end

    task automatic check1(input string nm, input logic [31:0] got,
                          input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            failures = failures + 1;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge (E0)
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hc,
                         input logic [31:0] lc, input logic acc,
                         input logic [31:0] eh, input logic [31:0] el,
                         input string nm);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.hi_cur = hc;
        bus.lo_cur = lc;
        if (acc) begin
            sb.push_back('{eh, el, cyc + 34, nm});
            n_push = n_push + 1;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 80; k++) begin
            if (!bus.busy && sb.size() == 0) break;
            @(negedge clk);
        end
        if (k == 80) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s_timeout: busy=%b pending=%0d", nm, bus.busy, sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        failures = 0;
        n_push = 0;
        n_done = 0;
        prev_done = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op = 3'b000;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.hi_cur = '0;
        bus.lo_cur = '0;
        repeat (3) @(negedge clk);
        check1("reset_outs",
               {26'd0, bus.busy, bus.done, bus.hi_write, bus.lo_write,
                |bus.hi_out, |bus.lo_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULT -2*3 with a DIVU start pulsed mid-operation
        issue(3'b000, 32'hFFFFFFFE, 32'h3, 0, 0, 1,
              32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg");
        check1("busy_after_e0", {31'd0, bus.busy}, 32'd1);
        repeat (4) @(negedge clk);
        issue(3'b011, 32'd100, 32'd7, 0, 0, 0, 0, 0, "ignored");
        wait_idle("mult_neg");

        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1,
              32'hFFFFFFFE, 32'h00000001, "multu_max");
        wait_idle("multu_max");
        issue(3'b000, 32'h7FFFFFFF, 32'h80000000, 0, 0, 1,
              32'hC0000000, 32'h80000000, "mult_big");
        wait_idle("mult_big");
        issue(3'b010, 32'hFFFFFFF9, 32'd2, 0, 0, 1,
              32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
        wait_idle("div_m7_2");
        issue(3'b010, 32'd7, 32'hFFFFFFFE, 0, 0, 1,
              32'h00000001, 32'hFFFFFFFD, "div_7_m2");
        wait_idle("div_7_m2");
        issue(3'b011, 32'd100, 32'd7, 0, 0, 1,
              32'd2, 32'd14, "divu_100_7");
        wait_idle("divu_100_7");
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1,
              32'h0, 32'h80000000, "div_ovf");
        wait_idle("div_ovf");
        issue(3'b011, 32'd5, 32'd0, 0, 0, 1,
              32'd5, 32'hFFFFFFFF, "divu_by0");
        wait_idle("divu_by0");
        issue(3'b010, 32'hFFFFFFF9, 32'd0, 0, 0, 1,
              32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0");
        wait_idle("div_neg_by0");

        // Illegal opcode while idle
        issue(3'b111, 32'd3, 32'd3, 0, 0, 0, 0, 0, "illegal");
        check1("illegal_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        check1("illegal_busy_later", {31'd0, bus.busy}, 32'd0);

`ifdef MULDIV_MADD_EN
        issue(3'b100, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 1,
              32'h1, 32'h0, "madd_carry");
        wait_idle("madd_carry");
        issue(3'b100, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd5, 1,
              32'h0, 32'd4, "madd_neg");
        wait_idle("madd_neg");
        issue(3'b101, 32'hFFFFFFFF, 32'd2, 32'd1, 32'd1, 1,
              32'h2, 32'hFFFFFFFF, "maddu");
        wait_idle("maddu");
`else
        issue(3'b100, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 0,
              0, 0, "madd_off");
        check1("madd_off_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        check1("madd_off_busy_later", {31'd0, bus.busy}, 32'd0);
`endif

        // Reset at E10 of a DIV: no strobe may ever appear for it
        issue(3'b010, 32'd1000, 32'd3, 0, 0, 0, 0, 0, "div_abort");
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check1("abort_outs",
               {26'd0, bus.busy, bus.done, bus.hi_write, bus.lo_write,
                |bus.hi_out, |bus.lo_out}, 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Back-to-back: second start sampled at E33 of the first
        issue(3'b001, 32'd6, 32'd7, 0, 0, 1, 32'd0, 32'd42, "b2b_first");
        repeat (32) @(negedge clk);
        issue(3'b011, 32'd100, 32'd7, 0, 0, 1, 32'd2, 32'd14, "b2b_second");
        wait_idle("b2b");

        repeat (5) @(negedge clk);
        check1("pending_left", sb.size(), 32'd0);
        check1("done_count", n_done, n_push);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide engine. It is the producer side of the HI/LO write interface of the register file.
- Accepts one MULT/MULTU/DIV/DIVU (optionally MADD/MADDU) operation, computes it over 32 iterations, then drives hi_out/lo_out with single-cycle hi_write/lo_write strobes.
- The register file captures these on the next clk edge. Sits beside the ALU in the execute stage; the controller stalls on busy.

Parameters:
- DATA_W, 32, operand and HI/LO width. Only 32 is supported.
- ITERS, 32, iteration count. Fixed equal to DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  operation request, sampled on clk edge.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU; 110/111 illegal.
- rs_val  in  32  operand A (multiplicand / dividend).
- rt_val  in  32  operand B (multiplier / divisor).
- hi_cur  in  32  current HI, used by MADD/MADDU only.
- lo_cur  in  32  current LO, used by MADD/MADDU only.
- busy  out  1  high from the accepting edge until done completes.
- done  out  1  one-cycle pulse, coincident with the write strobes.
- hi_out  out  32  result for HI.
- lo_out  out  32  result for LO.
- hi_write  out  1  HI write strobe.
- lo_write  out  1  LO write strobe.

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; busy=0, done=0, hi_write=0, lo_write=0, hi_out=0, lo_out=0; counter and datapath registers cleared.
- Reset mid-operation aborts with no write strobe. Reset has priority over start.
- FSM states: IDLE, CALC, FIX.
  - IDLE: start=1 with a legal op at edge E0 latches op, rs_val, rt_val, hi_cur and lo_cur; counter=0; go to CALC; busy=1 after E0.
  - Start with an illegal op is ignored: stays IDLE, busy stays 0.
  - CALC: one iteration per edge, E1..E32. The counter increments each edge; after the 32nd iteration (counter==31 at the edge), go to FIX.
  - FIX: at edge E33, apply sign correction and accumulation, register hi_out/lo_out, and set done=1, hi_write=1, lo_write=1 for exactly one cycle. Next state IDLE; busy=0 after E33.
  - Register file commits at E34. A new start is accepted at E33 or later. Latency is fixed at 33 cycles for every op.
- start while busy=1 is ignored. Operands are not re-sampled.
- Multiply:
  - Shift-add on magnitudes into a 64-bit product.
  - MULT: operands are made absolute at latch time; the product is negated in FIX if the signs differ.
  - MULTU: no sign handling.
  - {hi_out,lo_out} = 64-bit product.
- MADD/MADDU: {hi_out,lo_out} = {hi_cur,lo_cur} + product, modulo 2^64. The product is signed for MADD and unsigned for MADDU.
- Divide:
  - Restoring, one quotient bit per iteration on magnitudes.
  - lo_out = quotient, truncated toward zero; hi_out = remainder.
  - DIV: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0.
- Divide by zero (rt_val=0, DIV or DIVU): still 33 cycles; lo_out=0xFFFFFFFF, hi_out=rs_val (the original dividend, not its magnitude).
- All arithmetic wraps modulo 2^64; there is no overflow flag.
- hi_out/lo_out hold their last value after FIX until the next FIX or reset.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: ops 100/101 are legal and accumulate into hi_cur/lo_cur as above.
- Undefined: ops 100/101 are treated as illegal and the start is ignored. hi_cur/lo_cur are unused (ports remain, no logic).

Test Plan:
- Reset then MULT: rs=0xFFFFFFFE (-2), rt=0x00000003, start at E0 -> busy 1 from E0; at E33 done=hi_write=lo_write=1 for one cycle, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, latency still 33.
- Start pulsed at E5 during a busy MULT, and op=111 while idle -> both ignored; exactly one done pulse per accepted op; busy stays 0 for the illegal op.
- rst_n=0 at E10 of a DIV -> next cycle busy=0 and all outputs 0; no hi_write/lo_write pulse ever occurs for that op. Back-to-back start at E33 is accepted.
- With MULDIV_MADD_EN: MADD hi_cur=0, lo_cur=0xFFFFFFFF, rs=1, rt=1 -> hi=1, lo=0. Without it, the same stimulus -> busy stays 0, no done.
